// File: rtl/jtag_uart_pkg.sv
// Shared definitions for the JTAG UART traffic generator.
// Register map of the JTAG UART slave, bit positions inside the data and
// control registers, the master FSM state type and the pattern step helper.
package jtag_uart_pkg;

  // Avalon word addresses of the JTAG UART registers
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Data register: RVALID flag and received character
  localparam int RVALID_BIT = 15;
  localparam int DATA_LSB   = 0;
  localparam int DATA_MSB   = 7;

  // Control register: free space in the transmit FIFO
  localparam int WSPACE_LSB = 16;
  localparam int WSPACE_MSB = 31;

  typedef enum logic [1:0] {
    IDLE,
    RD_DATA,
    CHK_SPACE,
    WRITE
  } state_e;

  // Next pattern character; wraps to first once last has been sent.
  function automatic logic [7:0] next_char(input logic [7:0] cur,
                                           input logic [7:0] first,
                                           input logic [7:0] last);
    return (cur >= last) ? first : cur + 8'd1;
  endfunction

endpackage

// File: rtl/jtag_uart_tick_gen.sv
// Service-period timer for the JTAG UART traffic generator.
// Ports:
//   clk     - system clock
//   reset_  - synchronous active-low reset
//   enable  - counts while high, holds the timer at zero while low
//   tick    - one-cycle pulse in the cycle the timer sits at PERIOD-1
module jtag_uart_tick_gen #(
  parameter int PERIOD = 1048576
) (
  input  logic clk,
  input  logic reset_,
  input  logic enable,
  output logic tick
);

  localparam int            TW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (!enable) begin
      timer_d = '0;
    end else if (timer_q == LAST) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // The parent latches this into its sticky pending flag on the wrap edge.
  assign tick = enable && (timer_q == LAST);

  always_ff @(posedge clk) begin
    if (!reset_) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/jtag_uart_traffic_gen.sv
// Avalon-MM master that exercises a JTAG UART slave.
// Pattern mode writes a wrapping character sequence in bursts once per
// PERIOD cycles; echo mode reads a received character and writes it back.
// With CHECK_SPACE the control register is polled before every write and
// the write (and the rest of the burst) is skipped when WSPACE is zero.
// Ports:
//   clk, reset_          - system clock, synchronous active-low reset
//   enable               - gates tick generation
//   av_address           - 0 = data register, 1 = control register
//   av_read_n/write_n    - active-low strobes (registered)
//   av_writedata         - {24'd0, char} (registered)
//   av_readdata          - read data, sampled only on read completion
//   av_waitrequest       - slave stall
//   tx_count / rx_count  - wrapping counts of chars written / received
//   busy                 - FSM not in IDLE
module jtag_uart_traffic_gen
  import jtag_uart_pkg::*;
#(
  parameter int PERIOD      = 1048576,
  parameter int BURST_LEN   = 1,
  parameter int CHAR_FIRST  = 48,
  parameter int CHAR_LAST   = 100,
  parameter int ECHO_EN     = 0,
  parameter int CHECK_SPACE = 1
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        enable,
  output logic        av_address,
  output logic        av_read_n,
  output logic        av_write_n,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic        busy
);

  localparam int            BW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [7:0]    CF         = 8'(CHAR_FIRST);
  localparam logic [7:0]    CL         = 8'(CHAR_LAST);
  // State that follows a successful data read or a non-final burst write
  localparam state_e        AFTER_RD   = (CHECK_SPACE != 0) ? CHK_SPACE : WRITE;
  localparam state_e        START_ST   = (ECHO_EN != 0) ? RD_DATA : AFTER_RD;

  state_e          state_q, state_d;
  logic            av_address_q, av_address_d;
  logic            av_read_n_q, av_read_n_d;
  logic            av_write_n_q, av_write_n_d;
  logic [31:0]     av_writedata_q, av_writedata_d;
  logic [15:0]     tx_count_q, tx_count_d;
  logic [15:0]     rx_count_q, rx_count_d;
  logic [7:0]      char_q, char_d;
  logic [7:0]      byte_q, byte_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            tick_pend_q, tick_pend_d;

  logic tick;
  logic strobe_on;
  logic done;
  logic issue;
  logic start;
  logic rvalid;
  logic wspace_zero;
  logic burst_last;
  logic unused_rd;

  jtag_uart_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk    (clk),
    .reset_ (reset_),
    .enable (enable),
    .tick   (tick)
  );

  // Every transaction state spends its first cycle with both strobes high
  // (issue), which also provides the mandatory idle cycle between
  // back-to-back transactions. The strobe then stays low until completion.
  assign strobe_on   = !av_read_n_q || !av_write_n_q;
  assign done        = strobe_on && !av_waitrequest;
  assign issue       = (state_q != IDLE) && !strobe_on && enable;
  assign start       = (state_q == IDLE) && tick_pend_q && enable;
  assign rvalid      = av_readdata[RVALID_BIT];
  assign wspace_zero = (av_readdata[WSPACE_MSB:WSPACE_LSB] == 16'd0);
  assign burst_last  = (burst_cnt_q == BURST_LAST);
  assign unused_rd   = ^av_readdata[RVALID_BIT-1:DATA_MSB+1];

  // State register
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = START_ST;
      end
      RD_DATA: begin
        if (!strobe_on && !enable) state_d = IDLE;
        else if (done)             state_d = (!enable || !rvalid) ? IDLE : AFTER_RD;
      end
      CHK_SPACE: begin
        if (!strobe_on && !enable) state_d = IDLE;
        else if (done)             state_d = (!enable || wspace_zero) ? IDLE : WRITE;
      end
      WRITE: begin
        if (!strobe_on && !enable) state_d = IDLE;
        else if (done)             state_d = (!enable || (ECHO_EN != 0) || burst_last) ? IDLE : AFTER_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    av_address_d   = av_address_q;
    av_read_n_d    = av_read_n_q;
    av_write_n_d   = av_write_n_q;
    av_writedata_d = av_writedata_q;
    tx_count_d     = tx_count_q;
    rx_count_d     = rx_count_q;
    char_d         = char_q;
    byte_d         = byte_q;
    burst_cnt_d    = burst_cnt_q;
    tick_pend_d    = tick_pend_q;

    // A fresh tick wins over consumption in the same cycle: it is a new tick.
    if (!enable)    tick_pend_d = 1'b0;
    else if (tick)  tick_pend_d = 1'b1;
    else if (start) tick_pend_d = 1'b0;

    if (start) burst_cnt_d = '0;

    if (issue) begin
      unique case (state_q)
        RD_DATA: begin
          av_read_n_d  = 1'b0;
          av_address_d = ADDR_DATA;
        end
        CHK_SPACE: begin
          av_read_n_d  = 1'b0;
          av_address_d = ADDR_CTRL;
        end
        WRITE: begin
          av_write_n_d   = 1'b0;
          av_address_d   = ADDR_DATA;
          av_writedata_d = {24'd0, (ECHO_EN != 0) ? byte_q : char_q};
        end
        default: ;
      endcase
    end

    if (done) begin
      av_read_n_d  = 1'b1;
      av_write_n_d = 1'b1;
      unique case (state_q)
        RD_DATA: begin
          if (rvalid) begin
            byte_d     = av_readdata[DATA_MSB:DATA_LSB];
            rx_count_d = rx_count_q + 16'd1;
          end
        end
        WRITE: begin
          tx_count_d = tx_count_q + 16'd1;
          if (ECHO_EN == 0) begin
            char_d = next_char(char_q, CF, CL);
            if (!burst_last) burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      av_address_q   <= ADDR_DATA;
      av_read_n_q    <= 1'b1;
      av_write_n_q   <= 1'b1;
      av_writedata_q <= '0;
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      char_q         <= CF;
      byte_q         <= '0;
      burst_cnt_q    <= '0;
      tick_pend_q    <= 1'b0;
    end else begin
      av_address_q   <= av_address_d;
      av_read_n_q    <= av_read_n_d;
      av_write_n_q   <= av_write_n_d;
      av_writedata_q <= av_writedata_d;
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      char_q         <= char_d;
      byte_q         <= byte_d;
      burst_cnt_q    <= burst_cnt_d;
      tick_pend_q    <= tick_pend_d;
    end
  end

  assign av_address   = av_address_q;
  assign av_read_n    = av_read_n_q;
  assign av_write_n   = av_write_n_q;
  assign av_writedata = av_writedata_q;
  assign tx_count     = tx_count_q;
  assign rx_count     = rx_count_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_jtag_uart_traffic_gen.sv
// Directed bench for jtag_uart_traffic_gen. Three instances cover
// pattern mode without space checks (A), pattern bursts with WSPACE
// polling (B) and echo mode (C). Inputs change 1 ns after the rising edge,
// outputs are sampled 1 ns after the falling edge.
module tb_jtag_uart_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- instance A: pattern, no space check, PERIOD 16
  logic        rst_a = 1'b0, en_a = 1'b1, wr_a = 1'b0;
  logic        a_address, a_read_n, a_write_n, a_busy;
  logic [31:0] a_writedata;
  logic [15:0] a_tx, a_rx;

  jtag_uart_traffic_gen #(.PERIOD(16), .BURST_LEN(1), .CHAR_FIRST(48), .CHAR_LAST(100),
                          .ECHO_EN(0), .CHECK_SPACE(0)) u_a (
    .clk(clk), .reset_(rst_a), .enable(en_a),
    .av_address(a_address), .av_read_n(a_read_n), .av_write_n(a_write_n),
    .av_writedata(a_writedata), .av_readdata(32'h0), .av_waitrequest(wr_a),
    .tx_count(a_tx), .rx_count(a_rx), .busy(a_busy));

  // ---------------- instance B: pattern bursts of 4 with WSPACE polling
  logic        rst_b = 1'b0, en_b = 1'b1, wr_b = 1'b0;
  logic [31:0] ctrl_b = 32'h0;
  logic        b_address, b_read_n, b_write_n, b_busy;
  logic [31:0] b_writedata, rdata_b;
  logic [15:0] b_tx, b_rx;
  assign rdata_b = b_address ? ctrl_b : 32'h0;

  jtag_uart_traffic_gen #(.PERIOD(64), .BURST_LEN(4), .CHAR_FIRST(48), .CHAR_LAST(100),
                          .ECHO_EN(0), .CHECK_SPACE(1)) u_b (
    .clk(clk), .reset_(rst_b), .enable(en_b),
    .av_address(b_address), .av_read_n(b_read_n), .av_write_n(b_write_n),
    .av_writedata(b_writedata), .av_readdata(rdata_b), .av_waitrequest(wr_b),
    .tx_count(b_tx), .rx_count(b_rx), .busy(b_busy));

  // ---------------- instance C: echo mode
  logic        rst_c = 1'b0, en_c = 1'b1, wr_c = 1'b0;
  logic [31:0] data_c = 32'h0001_8041;
  logic        c_address, c_read_n, c_write_n, c_busy;
  logic [31:0] c_writedata;
  logic [15:0] c_tx, c_rx;

  jtag_uart_traffic_gen #(.PERIOD(16), .BURST_LEN(1), .CHAR_FIRST(48), .CHAR_LAST(100),
                          .ECHO_EN(1), .CHECK_SPACE(0)) u_c (
    .clk(clk), .reset_(rst_c), .enable(en_c),
    .av_address(c_address), .av_read_n(c_read_n), .av_write_n(c_write_n),
    .av_writedata(c_writedata), .av_readdata(data_c), .av_waitrequest(wr_c),
    .tx_count(c_tx), .rx_count(c_rx), .busy(c_busy));

  // ---------------- bus monitors: completed writes, reads per address,
  // hold-while-stalled and strobe-gap violations
  logic [31:0] wq_a[$], wq_b[$], wq_c[$];
  int          t_a[$];
  int          crd_a = 0, drd_a = 0, crd_b = 0, drd_b = 0, crd_c = 0, drd_c = 0;
  int          viol_a = 0, viol_b = 0, viol_c = 0;
  logic        ps_a = 0, pd_a = 0, ps_b = 0, pd_b = 0, ps_c = 0, pd_c = 0;
  logic [34:0] snap_a, snap_b, snap_c;

  always @(negedge clk) begin
    if (!rst_a) begin
      ps_a = 1'b0; pd_a = 1'b0;
    end else begin
      if (ps_a && (snap_a !== {a_address, a_read_n, a_write_n, a_writedata})) viol_a++;
      if (pd_a && !(a_read_n && a_write_n)) viol_a++;
      ps_a   = (!a_read_n || !a_write_n) && wr_a;
      pd_a   = (!a_read_n || !a_write_n) && !wr_a;
      snap_a = {a_address, a_read_n, a_write_n, a_writedata};
      if (pd_a) begin
        if (!a_write_n) begin wq_a.push_back(a_writedata); t_a.push_back(cyc_n); end
        else if (a_address) crd_a++;
        else drd_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      ps_b = 1'b0; pd_b = 1'b0;
    end else begin
      if (ps_b && (snap_b !== {b_address, b_read_n, b_write_n, b_writedata})) viol_b++;
      if (pd_b && !(b_read_n && b_write_n)) viol_b++;
      ps_b   = (!b_read_n || !b_write_n) && wr_b;
      pd_b   = (!b_read_n || !b_write_n) && !wr_b;
      snap_b = {b_address, b_read_n, b_write_n, b_writedata};
      if (pd_b) begin
        if (!b_write_n) wq_b.push_back(b_writedata);
        else if (b_address) crd_b++;
        else drd_b++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_c) begin
      ps_c = 1'b0; pd_c = 1'b0;
    end else begin
      if (ps_c && (snap_c !== {c_address, c_read_n, c_write_n, c_writedata})) viol_c++;
      if (pd_c && !(c_read_n && c_write_n)) viol_c++;
      ps_c   = (!c_read_n || !c_write_n) && wr_c;
      pd_c   = (!c_read_n || !c_write_n) && !wr_c;
      snap_c = {c_address, c_read_n, c_write_n, c_writedata};
      if (pd_c) begin
        if (!c_write_n) wq_c.push_back(c_writedata);
        else if (c_address) crd_c++;
        else drd_c++;
      end
    end
  end

  // ---------------- helpers
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic drv();
    @(posedge clk); #1;
  endtask

  task automatic smp_n(input int n);
    for (int i = 0; i < n; i++) smp();
  endtask

  int          n0;
  int          act;
  logic [31:0] wd0;

  initial begin
    // ---------------- reset state
    smp_n(3);
    chk("rst_write_n", {31'd0, a_write_n}, 32'd1);
    chk("rst_read_n",  {31'd0, a_read_n},  32'd1);
    chk("rst_addr",    {31'd0, a_address}, 32'd0);
    chk("rst_wdata",   a_writedata,        32'd0);
    chk("rst_tx",      {16'd0, a_tx},      32'd0);
    chk("rst_rx",      {16'd0, a_rx},      32'd0);
    chk("rst_busy",    {31'd0, a_busy},    32'd0);

    // ---------------- 1: pattern sequence and wrap
    drv(); rst_a = 1'b1;
    for (int i = 0; i < 1000 && wq_a.size() < 54; i++) smp();
    chk("t1_nwrites", wq_a.size(), 32'd54);
    smp_n(2);
    if (wq_a.size() >= 54) begin
      chk("t1_w1",   wq_a[0],  32'h30);
      chk("t1_w2",   wq_a[1],  32'h31);
      chk("t1_w3",   wq_a[2],  32'h32);
      chk("t1_w53",  wq_a[52], 32'h64);
      chk("t1_w54",  wq_a[53], 32'h30);
      chk("t1_intv", t_a[1] - t_a[0], 32'd16);
    end
    chk("t1_tx", {16'd0, a_tx}, 32'd54);

    // ---------------- 2: write held by waitrequest for 5 cycles
    drv(); wr_a = 1'b1;
    for (int i = 0; i < 40 && a_write_n; i++) smp();
    wd0 = a_writedata;
    chk("t2_wdata",  wd0,               32'h31);
    chk("t2_busy",   {31'd0, a_busy},   32'd1);
    for (int k = 2; k <= 5; k++) begin
      smp();
      chk("t2_hold", {a_address, a_write_n, a_tx, a_writedata[7:0]}, {1'b0, 1'b0, 16'd54, 8'h31});
    end
    drv(); wr_a = 1'b0;
    smp();
    chk("t2_cyc6", {a_write_n, a_writedata[7:0], a_tx}, {1'b0, 8'h31, 16'd54});
    smp();
    chk("t2_strobe_hi", {31'd0, a_write_n}, 32'd1);
    chk("t2_tx",        {16'd0, a_tx},      32'd55);

    // ---------------- 6: reset during a stalled write, then enable low
    drv(); wr_a = 1'b1;
    for (int i = 0; i < 40 && a_write_n; i++) smp();
    chk("t6_stalled", {31'd0, a_write_n}, 32'd0);
    drv(); rst_a = 1'b0;
    drv(); rst_a = 1'b1; wr_a = 1'b0;
    smp();
    chk("t6_write_n", {31'd0, a_write_n}, 32'd1);
    chk("t6_wdata",   a_writedata,        32'd0);
    chk("t6_counts",  {a_tx, a_rx},       32'd0);
    chk("t6_busy",    {31'd0, a_busy},    32'd0);
    n0 = wq_a.size();
    for (int i = 0; i < 40 && wq_a.size() == n0; i++) smp();
    chk("t6_first_char", wq_a[wq_a.size()-1], 32'h30);
    drv(); en_a = 1'b0;
    act = 0;
    for (int i = 0; i < 100; i++) begin
      smp();
      if (!a_write_n || !a_read_n || a_busy) act++;
    end
    chk("t6_quiet", act, 32'd0);
    chk("t6_tx", {16'd0, a_tx}, 32'd1);
    drv(); en_a = 1'b1;
    n0 = wq_a.size();
    for (int i = 0; i < 40 && wq_a.size() == n0; i++) smp();
    chk("t6_resume_char", wq_a[wq_a.size()-1], 32'h31);

    // ---------------- 3: no WSPACE -> read only, no write
    drv(); rst_b = 1'b1;
    for (int i = 0; i < 150 && crd_b < 1; i++) smp();
    smp_n(3);
    chk("t3_ctrl_reads", crd_b,           32'd1);
    chk("t3_writes",     wq_b.size(),     32'd0);
    chk("t3_tx",         {16'd0, b_tx},   32'd0);
    chk("t3_busy",       {31'd0, b_busy}, 32'd0);
    drv(); ctrl_b = 32'h0040_0000;

    // ---------------- 4: burst of 4, then WSPACE drops mid-burst
    for (int i = 0; i < 150 && wq_b.size() < 4; i++) smp();
    smp_n(3);
    chk("t4_nwrites", wq_b.size(), 32'd4);
    if (wq_b.size() >= 4) begin
      chk("t4_b1_0", wq_b[0], 32'h30);
      chk("t4_b1_3", wq_b[3], 32'h33);
    end
    chk("t4_reads1", crd_b,         32'd5);
    chk("t4_tx1",    {16'd0, b_tx}, 32'd4);
    for (int i = 0; i < 150 && b_tx < 16'd6; i++) smp();
    ctrl_b = 32'h0;
    for (int i = 0; i < 30 && b_busy; i++) smp();
    smp_n(2);
    chk("t4_tx2",     {16'd0, b_tx}, 32'd6);
    chk("t4_nwrites2", wq_b.size(),  32'd6);
    chk("t4_reads2",  crd_b,         32'd8);
    if (wq_b.size() >= 6) begin
      chk("t4_b2_0", wq_b[4], 32'h34);
      chk("t4_b2_1", wq_b[5], 32'h35);
    end
    drv(); ctrl_b = 32'h0040_0000;
    for (int i = 0; i < 150 && wq_b.size() < 10; i++) smp();
    smp_n(3);
    chk("t4_nwrites3", wq_b.size(), 32'd10);
    if (wq_b.size() >= 10) begin
      chk("t4_b3_0", wq_b[6], 32'h36);
      chk("t4_b3_3", wq_b[9], 32'h39);
    end
    chk("t4_tx3", {16'd0, b_tx}, 32'd10);

    // ---------------- 5: echo mode
    drv(); rst_c = 1'b1;
    for (int i = 0; i < 60 && wq_c.size() < 1; i++) smp();
    data_c = 32'h0;
    smp_n(3);
    chk("t5_nwrites", wq_c.size(), 32'd1);
    if (wq_c.size() >= 1) chk("t5_echo", wq_c[0], 32'h0000_0041);
    chk("t5_tx",  {16'd0, c_tx}, 32'd1);
    chk("t5_rx",  {16'd0, c_rx}, 32'd1);
    for (int i = 0; i < 40 && drd_c < 2; i++) smp();
    smp_n(3);
    chk("t5_dreads",   drd_c,           32'd2);
    chk("t5_nwrites2", wq_c.size(),     32'd1);
    chk("t5_counts2",  {c_tx, c_rx},    {16'd1, 16'd1});
    chk("t5_creads",   crd_c,           32'd0);
    chk("t5_busy",     {31'd0, c_busy}, 32'd0);

    // ---------------- bus protocol observed throughout
    chk("proto_a", viol_a, 32'd0);
    chk("proto_b", viol_b, 32'd0);
    chk("proto_c", viol_c, 32'd0);
    chk("reads_a", crd_a + drd_a, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_uart_traffic_gen.md
Name: jtag_uart_traffic_gen

Overview:
Parametrised Avalon-MM master that drives a JTAG UART slave (data register at address 0, control register at address 1). It has two modes. Pattern mode writes a wrapping character sequence in bursts once per programmable period. Echo mode reads received characters and writes them back. Optional WSPACE flow control polls the control register before every write. It sits in the top level between the system clock/reset and the JTAG UART instance, and replaces the hard-coded single-byte writer.

Parameters:
PERIOD, 1048576, cycles between service ticks; must be >= 2.
BURST_LEN, 1, characters written per tick in pattern mode; must be >= 1.
CHAR_FIRST, 48, first character of the pattern.
CHAR_LAST, 100, last character of the pattern; the sequence wraps to CHAR_FIRST after it; must be >= CHAR_FIRST.
ECHO_EN, 0, 0 = pattern mode, 1 = echo mode.
CHECK_SPACE, 1, 1 = read the control register and require WSPACE != 0 before each write.

Ports:
clk  in  1  system clock
reset_  in  1  synchronous active-low reset
enable  in  1  gates tick generation
av_address  out  1  Avalon address (0 = data, 1 = control)
av_read_n  out  1  Avalon read strobe, active low
av_write_n  out  1  Avalon write strobe, active low
av_writedata  out  32  write data, {24'd0, char}
av_readdata  in  32  read data
av_waitrequest  in  1  slave stall
tx_count  out  16  characters written, wraps
rx_count  out  16  characters received with RVALID=1, wraps
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset_ low at posedge) forces:
  - av_read_n=1, av_write_n=1, av_address=0, av_writedata=0
  - tx_count=0, rx_count=0, char=CHAR_FIRST, burst_cnt=0, timer=0, tick_pend=0, state=IDLE
  - Applies mid-transaction: strobes go high at that edge and the transaction is abandoned.
- All Avalon outputs are registered.
- Transaction rules:
  - A transaction completes in the cycle where a strobe is low and av_waitrequest=0.
  - Address, strobe and writedata are held stable while av_waitrequest=1.
  - Strobes are high for at least one cycle between transactions.
  - av_readdata is sampled only in the completion cycle of a read.
- Timer:
  - Width $clog2(PERIOD). Increments while enable=1; at PERIOD-1 it wraps to 0 and sets tick_pend.
  - tick_pend is a sticky single bit: ticks arriving while it is already set are lost (collapsed).
  - enable=0 holds the timer at 0 and clears tick_pend. A transaction in progress still completes, then the FSM returns to IDLE.
- States:
  - IDLE: when tick_pend=1, clear it and set burst_cnt=0. Go to RD_DATA if ECHO_EN, else CHK_SPACE (or WRITE if CHECK_SPACE=0).
  - RD_DATA: read address 0. On completion, if readdata[15] (RVALID)=1: byte=readdata[7:0], rx_count+1, go to CHK_SPACE/WRITE. Otherwise go to IDLE.
  - CHK_SPACE: read address 1. On completion, if readdata[31:16]=0, go to IDLE with char and byte unchanged and the rest of the burst dropped. Otherwise go to WRITE.
  - WRITE: av_write_n=0, address 0, writedata={24'd0, byte}; in pattern mode byte=char. On completion:
    - tx_count+1.
    - Pattern mode: char = (char >= CHAR_LAST) ? CHAR_FIRST : char+1.
    - Echo mode, or burst_cnt == BURST_LEN-1: go to IDLE. Otherwise burst_cnt+1 and go to CHK_SPACE/WRITE.
- A tick arriving while busy sets tick_pend and is serviced on the next return to IDLE.
- Character arithmetic is 8-bit; no overflow is possible given CHAR_LAST <= 255.

Decomposition:
- Package jtag_uart_pkg:
  - ADDR_DATA=0, ADDR_CTRL=1
  - RVALID_BIT=15, DATA_LSB/MSB=0/7, WSPACE_LSB/MSB=16/31
  - State enum {IDLE, RD_DATA, CHK_SPACE, WRITE}
- Sub-module jtag_uart_tick_gen (params PERIOD; ports clk, reset_, enable, tick) holds the period timer. The FSM, counters and tick_pend stay in the parent.

Test Plan:
1. PERIOD=16, BURST_LEN=1, CHECK_SPACE=0, waitrequest=0 -> writes 0x30, 0x31, ... one per 16 cycles; write 53 carries 0x64 and write 54 carries 0x30; tx_count=54.
2. waitrequest held 1 for 5 cycles during WRITE -> address, writedata and av_write_n stable for 6 cycles; tx_count increments by exactly 1; strobe high the following cycle.
3. CHECK_SPACE=1, control readdata=0x0000_0000 -> one read of address 1, no write, char stays 0x30; next tick with readdata=0x0040_0000 -> read then write of 0x30.
4. BURST_LEN=4, WSPACE=64 -> per tick 4 read/write pairs carrying 0x30..0x33. Next burst with WSPACE forced to 0 after its 2nd write -> 0x34, 0x35 written, then return to IDLE; tx_count=6 and the following burst resumes at 0x36.
5. ECHO_EN=1: data read returns 0x0001_8041 -> write of 0x0000_0041, rx_count=1, tx_count=1; data read returns 0x0000_0000 -> no write, counts unchanged.
6. reset_ low for 1 cycle during WRITE with waitrequest=1 -> next cycle av_write_n=1, counts 0, char 0x30. Then enable=0 for 100 cycles -> no strobes and busy=0.
